// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Holds the loader state encoding and the header/word byte counts.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        WRITE,
        CHK,
        DONE,
        ERR
    } state_t;

    localparam int HDR_BYTES  = 4;
    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte packer: collects bytes into a 32-bit word.
// Ports: clock/reset, clear (restart at byte 0), load (byte accepted),
// last (index of final byte), byte_in; word (stored bytes merged with the
// byte being loaded this cycle), full (this load completes the word).
module byte_packer (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        load,
    input  logic [1:0]  last,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        full
);

    logic [1:0]  idx;
    logic [31:0] acc;

    // Word as it will look after this cycle's byte lands, so the
    // caller can act on the complete value on the completing edge.
    always_comb begin
        word = acc;
        if (load) begin
            word[{idx, 3'b000} +: 8] = byte_in;
        end
    end

    assign full = load && (idx == last);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx <= '0;
            acc <= '0;
        end else if (clear) begin
            idx <= '0;
            acc <= '0;
        end else if (load) begin
            acc <= word;
            idx <= full ? 2'd0 : idx + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: byte stream -> 4-byte LE word count -> LE words
// written to instruction memory. Ports: clock, reset (async, high),
// start, byte_in/byte_valid/byte_ready stream, wr_en/wr_addr/wr_data
// memory write port, busy/done/error status, words_written count.
// Optional macro IMEM_LOADER_CHECKSUM_EN adds a trailing 4-byte sum check.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = 15,
    parameter int BASE_ADDR = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_written
);

    // Largest word count that fits between BASE_ADDR and the top of memory.
    localparam logic [32:0] LIMIT = 33'((64'd1 << ADDR_W) - 64'(BASE_ADDR));

    state_t          state;
    state_t          state_nx;
    logic            accept;
    logic            start_ok;
    logic            full;
    logic [1:0]      last;
    logic [31:0]     word;
    logic [ADDR_W:0] n_words;
    logic [ADDR_W:0] count_nx;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]     sum;
    localparam state_t END_ST = CHK;
`else
    localparam state_t END_ST = DONE;
`endif

    assign accept   = byte_valid && byte_ready;
    assign start_ok = start && (state == IDLE || state == DONE || state == ERR);
    assign count_nx = words_written + 1'b1;
    assign last     = (state == HDR) ? 2'(HDR_BYTES - 1) : 2'(WORD_BYTES - 1);

    byte_packer u_packer (
        .clock   (clock),
        .reset   (reset),
        .clear   (start_ok),
        .load    (accept),
        .last    (last),
        .byte_in (byte_in),
        .word    (word),
        .full    (full)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        byte_ready = 1'b0;
        wr_en      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nx = HDR;
            end
            HDR: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (full) begin
                    if (word == 32'd0) begin
                        state_nx = END_ST;
                    end else if ({1'b0, word} > LIMIT) begin
                        state_nx = ERR;
                    end else begin
                        state_nx = DATA;
                    end
                end
            end
            DATA: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (full) state_nx = WRITE;
            end
            WRITE: begin
                wr_en    = 1'b1;
                busy     = 1'b1;
                state_nx = (count_nx == n_words) ? END_ST : DATA;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (full) state_nx = (word == sum) ? DONE : ERR;
            end
`endif
            DONE: begin
                done = 1'b1;
                if (start) state_nx = HDR;
            end
            ERR: begin
                error = 1'b1;
                if (start) state_nx = HDR;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            n_words       <= '0;
            words_written <= '0;
            wr_addr       <= '0;
            wr_data       <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum           <= '0;
`endif
        end else begin
            if (start_ok) begin
                words_written <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                sum           <= '0;
`endif
            end
            if (state == HDR && full) begin
                n_words <= word[ADDR_W:0];
            end
            // Address/data are latched as the word completes so they
            // are stable through WRITE and hold afterwards.
            if (state == DATA && full) begin
                wr_data <= word;
                wr_addr <= ADDR_W'(BASE_ADDR) + words_written[ADDR_W-1:0];
            end
            if (state == WRITE) begin
                words_written <= count_nx;
`ifdef IMEM_LOADER_CHECKSUM_EN
                sum           <= sum + wr_data;
`endif
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as bytes
// are sent; a negedge monitor pops and compares on every wr_en.
module tb_imem_loader;

    localparam int ADDR_W = 15;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [7:0]        byte_in = 8'h00;
    logic              byte_valid = 1'b0;
    logic              byte_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_written;

    int n_checks = 0;
    int n_pass   = 0;
    int n_writes = 0;

    logic [63:0] exp_q[$];
    logic [31:0] words[$];

    imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .byte_in       (byte_in),
        .byte_valid    (byte_valid),
        .byte_ready    (byte_ready),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .words_written (words_written)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Monitor: every write strobe must match the oldest queued expectation.
    always @(negedge clock) begin
        if (!reset && wr_en) begin
            logic [63:0] e;
            n_writes++;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                         wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 64'(wr_addr), {32'd0, e[63:32]});
                check("wr_data", 64'(wr_data), {32'd0, e[31:0]});
            end
        end
    end

    task automatic pulse_start();
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        @(negedge clock);
        while (!byte_ready && t < 100) begin
            @(negedge clock);
            t++;
        end
        if (t >= 100) check("byte_timeout", 64'd1, 64'd0);
        @(posedge clock); #1;
    endtask

    task automatic gap(input int n);
        byte_valid = 1'b0;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        for (int k = 0; k < 4; k++) begin
            if (gaps && $urandom_range(0, 1) == 1) gap($urandom_range(1, 3));
            send_byte(w[8*k +: 8]);
        end
    endtask

    // Full load of words[]: header, queued expectations, payload, checksum.
    task automatic send_load(input bit gaps, input logic [31:0] cs_bias,
                             input int busy_start_at);
        logic [31:0] n;
        logic [31:0] s;
        n = 32'(words.size());
        s = cs_bias;
        pulse_start();
        send_word(n, gaps);
        for (int i = 0; i < words.size(); i++) begin
            if (i == busy_start_at) begin
                gap(1);
                pulse_start();
            end
            exp_q.push_back({32'(i), words[i]});
            s = s + words[i];
            send_word(words[i], gaps);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(s, gaps);
`endif
        byte_valid = 1'b0;
    endtask

    task automatic wait_end();
        int t;
        t = 0;
        while (!done && !error && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (t >= 50) check("end_timeout", 64'd1, 64'd0);
        @(negedge clock);
    endtask

    initial begin
        int w0;

        repeat (3) @(posedge clock);
        #1;
        check("reset_outputs",
              {15'd0, byte_ready, wr_en, wr_addr, wr_data, busy, done,
               error, words_written},
              64'd0);
        reset = 1'b0;
        @(negedge clock);
        check("idle_ready", 64'(byte_ready), 64'd0);

        // Two-word program.
        words = '{32'h0000_0013, 32'h0010_0093};
        w0 = n_writes;
        send_load(1'b0, 32'd0, -1);
        wait_end();
        check("t1_done", 64'(done), 64'd1);
        check("t1_error", 64'(error), 64'd0);
        check("t1_count", 64'(words_written), 64'd2);
        check("t1_writes", 64'(n_writes - w0), 64'd2);
        check("t1_queue", 64'(exp_q.size()), 64'd0);

        // Zero-length load.
        w0 = n_writes;
        pulse_start();
        send_word(32'd0, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(32'd0, 1'b0);
`endif
        byte_valid = 1'b0;
        @(negedge clock);
        check("t2_done", 64'(done), 64'd1);
        check("t2_count", 64'(words_written), 64'd0);
        check("t2_writes", 64'(n_writes - w0), 64'd0);

        // Oversized header: 0x8001 words > 32768.
        w0 = n_writes;
        pulse_start();
        send_word(32'h0000_8001, 1'b0);
        byte_valid = 1'b0;
        @(negedge clock);
        check("t3_error", 64'(error), 64'd1);
        check("t3_done", 64'(done), 64'd0);
        check("t3_ready", 64'(byte_ready), 64'd0);
        check("t3_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clock);
        check("t3_writes", 64'(n_writes - w0), 64'd0);

        // 16 words, gap-free then with random gaps plus a start while busy.
        words = '{32'h0000_0013, 32'h0010_0093, 32'h0020_0113, 32'h0030_0193,
                  32'h0040_0213, 32'hDEAD_BEEF, 32'h0000_0000, 32'hFFFF_FFFF,
                  32'h1234_5678, 32'h8765_4321, 32'h0000_006F, 32'hFE00_0EE3,
                  32'h0080_0067, 32'hA5A5_5A5A, 32'h0102_0304, 32'h7FFF_FFFF};
        for (int pass = 0; pass < 2; pass++) begin
            w0 = n_writes;
            send_load(pass == 1, 32'd0, (pass == 1) ? 5 : -1);
            wait_end();
            check("t4_done", 64'(done), 64'd1);
            check("t4_count", 64'(words_written), 64'd16);
            check("t4_writes", 64'(n_writes - w0), 64'd16);
            check("t4_queue", 64'(exp_q.size()), 64'd0);
        end

        // Reset after two bytes of the third word.
        words = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        w0 = n_writes;
        pulse_start();
        send_word(32'd4, 1'b0);
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back({32'(i), words[i]});
            send_word(words[i], 1'b0);
        end
        send_byte(8'h33);
        send_byte(8'h33);
        #2 reset = 1'b1;
        #1;
        check("t5_reset_outputs",
              {15'd0, byte_ready, wr_en, wr_addr, wr_data, busy, done,
               error, words_written},
              64'd0);
        byte_valid = 1'b0;
        repeat (3) @(negedge clock);
        check("t5_writes", 64'(n_writes - w0), 64'd2);
        check("t5_queue", 64'(exp_q.size()), 64'd0);
        reset = 1'b0;
        words = '{32'hCAFE_0001, 32'hCAFE_0002};
        w0 = n_writes;
        send_load(1'b0, 32'd0, -1);
        wait_end();
        check("t5_done", 64'(done), 64'd1);
        check("t5_count", 64'(words_written), 64'd2);
        check("t5_reload_writes", 64'(n_writes - w0), 64'd2);

`ifdef IMEM_LOADER_CHECKSUM_EN
        words = '{32'h0000_0001, 32'h0000_0002};
        w0 = n_writes;
        send_load(1'b0, 32'd0, -1);
        wait_end();
        check("cs_ok_done", 64'(done), 64'd1);
        check("cs_ok_error", 64'(error), 64'd0);
        w0 = n_writes;
        send_load(1'b0, 32'd1, -1);
        wait_end();
        check("cs_bad_error", 64'(error), 64'd1);
        check("cs_bad_done", 64'(done), 64'd0);
        check("cs_bad_writes", 64'(n_writes - w0), 64'd2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
